// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line and oversampling tick in, recovered frame and status out.
interface uart_rx_if #(
  parameter int data_wd = 8
);
  logic               rx;
  logic               tick;
  logic [data_wd-1:0] dout;
  logic               rx_done;
  logic               rx_busy;
  logic               parity_err;
  logic               frame_err;

  modport master (
    output rx, tick,
    input  dout, rx_done, rx_busy, parity_err, frame_err
  );

  modport slave (
    input  rx, tick,
    output dout, rx_done, rx_busy, parity_err, frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input sync, mid-bit sampling on the shared oversampling tick,
// one-cycle rx_done with held data, parity and framing status.
module uart_rx #(
  parameter int BAUD              = 9600,
  parameter int clk_freq          = 50_000_000,
  parameter int oversampling_rate = 16,
  parameter int data_wd           = 8,
  parameter int parity            = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int TCW = $clog2(oversampling_rate);
  localparam int BIW = $clog2(data_wd + 1);
  localparam bit PAR_EN = (parity == 1) || (parity == 2);
  localparam logic [TCW-1:0] HALF = TCW'(oversampling_rate / 2 - 1);
  localparam logic [TCW-1:0] FULL = TCW'(oversampling_rate - 1);
  localparam logic [BIW-1:0] LAST = BIW'(data_wd - 1);

  if (oversampling_rate < 4 || (oversampling_rate % 2) != 0 ||
      clk_freq / BAUD < oversampling_rate) begin : g_bad_cfg
    $error("uart_rx: unusable oversampling configuration");
  end

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_START  = 6'b000010,
    S_DATA   = 6'b000100,
    S_PARITY = 6'b001000,
    S_STOP   = 6'b010000,
    S_DONE   = 6'b100000
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         sync_q;
  logic [TCW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BIW-1:0]     bit_idx_q, bit_idx_d;
  logic [data_wd-1:0] shift_q, shift_d;
  logic               par_bad_q, par_bad_d;
  logic               stop_bad_q, stop_bad_d;
  logic               line_idle_seen_q, line_idle_seen_d;
  logic [data_wd-1:0] dout_q, dout_d;
  logic               parity_err_q, parity_err_d;
  logic               frame_err_q, frame_err_d;
  logic               rx_s;
  logic               exp_par;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q           <= 2'b11;
      state_q          <= S_IDLE;
      tick_cnt_q       <= '0;
      bit_idx_q        <= '0;
      shift_q          <= '0;
      par_bad_q        <= 1'b0;
      stop_bad_q       <= 1'b0;
      line_idle_seen_q <= 1'b1;
      dout_q           <= '0;
      parity_err_q     <= 1'b0;
      frame_err_q      <= 1'b0;
    end else begin
      sync_q           <= {sync_q[0], bus.rx};
      state_q          <= state_d;
      tick_cnt_q       <= tick_cnt_d;
      bit_idx_q        <= bit_idx_d;
      shift_q          <= shift_d;
      par_bad_q        <= par_bad_d;
      stop_bad_q       <= stop_bad_d;
      line_idle_seen_q <= line_idle_seen_d;
      dout_q           <= dout_d;
      parity_err_q     <= parity_err_d;
      frame_err_q      <= frame_err_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    tick_cnt_d       = bus.tick ? tick_cnt_q + TCW'(1) : tick_cnt_q;
    bit_idx_d        = bit_idx_q;
    shift_d          = shift_q;
    par_bad_d        = par_bad_q;
    stop_bad_d       = stop_bad_q;
    line_idle_seen_d = line_idle_seen_q;
    dout_d           = dout_q;
    parity_err_d     = parity_err_q;
    frame_err_d      = frame_err_q;
    exp_par          = (parity == 1) ? ~^shift_q : ^shift_q;

    unique case (state_q)
      S_IDLE: begin
        // A line still low after a bad stop bit must go high before we re-arm.
        if (rx_s) begin
          line_idle_seen_d = 1'b1;
        end else if (line_idle_seen_q) begin
          state_d          = S_START;
          par_bad_d        = 1'b0;
          stop_bad_d       = 1'b0;
          line_idle_seen_d = 1'b0;
        end
      end
      S_START: begin
        if (bus.tick && tick_cnt_q == HALF) begin
          if (rx_s) begin
            state_d          = S_IDLE;
            line_idle_seen_d = 1'b1;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end
      end
      S_DATA: begin
        if (bus.tick && tick_cnt_q == FULL) begin
          shift_d    = data_wd'({rx_s, shift_q} >> 1);
          tick_cnt_d = '0;
          bit_idx_d  = bit_idx_q + BIW'(1);
          if (bit_idx_q == LAST) state_d = PAR_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bus.tick && tick_cnt_q == FULL) begin
          par_bad_d = (rx_s != exp_par);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        // Results are registered on the stop sample so they are already valid
        // in the DONE cycle alongside the strobe.
        if (bus.tick && tick_cnt_q == FULL) begin
          stop_bad_d       = ~rx_s;
          line_idle_seen_d = rx_s;
          dout_d           = shift_q;
          parity_err_d     = PAR_EN & par_bad_q;
          frame_err_d      = ~rx_s;
          state_d          = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) tick_cnt_d = '0;
  end

  assign bus.dout       = dout_q;
  assign bus.rx_done    = (state_q == S_DONE);
  assign bus.rx_busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;

endmodule
